time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, system clock rate in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default CLOCK_FREQ/100, stable-input cycles required to accept a key change.
REQ-003 Parameter HOLD_CYCLES, default CLOCK_FREQ/2, held time before auto-repeat starts.
REQ-004 Parameter REPEAT_CYCLES, default CLOCK_FREQ/10, auto-repeat pulse period.
REQ-005 Parameter TIMEOUT_CYCLES, default 10*CLOCK_FREQ, inactivity time before leaving set mode.
REQ-006 Parameter BLINK_CYCLES, default CLOCK_FREQ/4, BLINK half-period.
REQ-007 CLK  input  1  system clock; all logic on rising edge.
REQ-008 RST  input  1  synchronous, active-low reset; one clock, synchronous active-low reset, no other clock domains.
REQ-009 KEY_MODE  input  1  raw asynchronous pushbutton, active-low (0 = pressed), selects the field being set.
REQ-010 KEY_INC  input  1  raw asynchronous pushbutton, active-low, increments the selected field.
REQ-011 INCREMENT  output  1  registered single-cycle pulse, one per requested increment.
REQ-012 ORDER  output  2  field select: 00 run, 01 seconds, 10 minutes, 11 hours.
REQ-013 SET_ACTIVE  output  1  high when ORDER != 00.
REQ-014 BLINK  output  1  display blink enable for the selected field.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer, then a debouncer whose level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the count to 0.
REQ-016 A press SHALL be the debounced 1->0 transition; INCREMENT from a press SHALL rise exactly DEBOUNCE_CYCLES+3 cycles after the raw edge of a clean (bounce-free) press.
REQ-017 Mode FSM SHALL step RUN(00) -> HOURS(11) -> MINUTES(10) -> SECONDS(01) -> RUN, one step per KEY_MODE press.
REQ-018 In any set state, TIMEOUT_CYCLES consecutive cycles with no press of either key and debounced KEY_INC released SHALL return the FSM to RUN; the timeout counter clears on every press and while KEY_INC is held.
REQ-019 Increment FSM states: IDLE, HOLD, REPEAT, LOCKOUT.
REQ-020 IDLE: KEY_INC press with ORDER != 00 SHALL emit one INCREMENT pulse and enter HOLD with hold counter cleared; with ORDER = 00 the press is ignored and FSM enters LOCKOUT.
REQ-021 HOLD: after HOLD_CYCLES cycles still held SHALL emit one pulse and enter REPEAT; release returns to IDLE with no pulse.
REQ-022 REPEAT: one pulse every REPEAT_CYCLES cycles while held; release returns to IDLE.
REQ-023 LOCKOUT: no pulses; debounced release returns to IDLE.
REQ-024 A KEY_MODE press in HOLD or REPEAT SHALL move the increment FSM to LOCKOUT in that same cycle, cancelling repeat.
REQ-025 KEY_MODE and KEY_INC presses detected in the same cycle: mode step SHALL take effect, no INCREMENT pulse, increment FSM enters LOCKOUT.
REQ-026 INCREMENT SHALL never be high on two consecutive cycles and never when ORDER = 00.
REQ-027 BLINK SHALL toggle every BLINK_CYCLES cycles while SET_ACTIVE, restart at 1 on every ORDER change, and be held 1 in RUN.
REQ-028 All counters SHALL be 32-bit, saturating at their terminal value, never wrapping.

Reset
REQ-029 While RST = 0 on a clock edge: ORDER = 00, INCREMENT = 0, SET_ACTIVE = 0, BLINK = 1, synchronizer and debounced levels = 1 (released), all counters = 0, increment FSM = IDLE.
REQ-030 A key held through reset release SHALL be seen as a new press after debounce; in RUN this produces no INCREMENT.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, TIMEOUT_CYCLES=100, BLINK_CYCLES=10)
REQ-031 Three clean KEY_MODE presses from reset -> ORDER 11, 10, 01; fourth -> 00, SET_ACTIVE low.
REQ-032 ORDER=11, clean KEY_INC press held 60 cycles -> pulse at edge+7, then edge+27, +35, +43, +51, +59; 6 pulses total, none after release.
REQ-033 KEY_INC toggling every 2 cycles for 30 cycles, then held low -> exactly one pulse, edge of final low +7.
REQ-034 ORDER=10, no key activity for 100 cycles -> ORDER 00 on cycle 100, BLINK 1.
REQ-035 Both keys pressed on same cycle in ORDER=00 -> ORDER 11, zero INCREMENT pulses until KEY_INC released and re-pressed.
REQ-036 RST low during REPEAT -> next cycle ORDER 00, INCREMENT 0, no pulses after RST high while key remains held.

Source files
------------

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock-display set controller: debounced MODE/INC keys, field select, auto-repeat increment
// Keys are active-low; every output is registered.
module time_set_ctrl #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 100,
  parameter int HOLD_CYCLES     = CLOCK_FREQ / 2,
  parameter int REPEAT_CYCLES   = CLOCK_FREQ / 10,
  parameter int TIMEOUT_CYCLES  = 10 * CLOCK_FREQ,
  parameter int BLINK_CYCLES    = CLOCK_FREQ / 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic       INCREMENT,
  output logic [1:0] ORDER,
  output logic       SET_ACTIVE,
  output logic       BLINK
);

  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BL_LAST   = 32'(BLINK_CYCLES - 1);

  localparam logic [1:0] ORD_RUN = 2'b00;
  localparam logic [1:0] ORD_SEC = 2'b01;
  localparam logic [1:0] ORD_MIN = 2'b10;
  localparam logic [1:0] ORD_HR  = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} inc_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Bit 0 is KEY_MODE, bit 1 is KEY_INC.
  logic [1:0]  raw;
  logic [1:0]  sync1, sync2, deb, deb_d;
  logic [31:0] db_cnt [2];

  assign raw = {KEY_INC, KEY_MODE};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      deb   <= 2'b11;
      deb_d <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= sat_inc(db_cnt[i]);
        end
      end
    end
  end

  logic mode_press, inc_press, inc_held;
  assign mode_press = deb_d[0] & ~deb[0];
  assign inc_press  = deb_d[1] & ~deb[1];
  assign inc_held   = ~deb[1];

  logic [31:0] to_cnt, blink_cnt, hold_cnt;
  logic [1:0]  order_nxt;
  inc_state_t  inc_state;

  always_comb begin
    order_nxt = ORDER;
    if (mode_press) begin
      case (ORDER)
        ORD_RUN: order_nxt = ORD_HR;
        ORD_HR:  order_nxt = ORD_MIN;
        ORD_MIN: order_nxt = ORD_SEC;
        default: order_nxt = ORD_RUN;
      endcase
    end else if (ORDER != ORD_RUN && !inc_press && !inc_held && to_cnt >= TO_LAST) begin
      order_nxt = ORD_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ORDER      <= ORD_RUN;
      SET_ACTIVE <= 1'b0;
      BLINK      <= 1'b1;
      to_cnt     <= '0;
      blink_cnt  <= '0;
    end else begin
      ORDER      <= order_nxt;
      SET_ACTIVE <= (order_nxt != ORD_RUN);
      if (order_nxt == ORD_RUN || mode_press || inc_press || inc_held)
        to_cnt <= '0;
      else
        to_cnt <= sat_inc(to_cnt);
      // Blink phase restarts lit whenever the selected field changes.
      if (order_nxt == ORD_RUN || order_nxt != ORDER) begin
        BLINK     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt >= BL_LAST) begin
        BLINK     <= ~BLINK;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= sat_inc(blink_cnt);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      inc_state <= IDLE;
      INCREMENT <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      INCREMENT <= 1'b0;
      case (inc_state)
        IDLE: begin
          if (inc_press) begin
            hold_cnt <= '0;
            if (mode_press || ORDER == ORD_RUN) begin
              inc_state <= LOCKOUT;
            end else begin
              INCREMENT <= 1'b1;
              inc_state <= HOLD;
            end
          end
        end
        HOLD, REPEAT: begin
          if (mode_press) begin
            inc_state <= LOCKOUT;
          end else if (!inc_held) begin
            inc_state <= IDLE;
          end else if (!INCREMENT &&
                       hold_cnt >= ((inc_state == HOLD) ? HOLD_LAST : REP_LAST)) begin
            INCREMENT <= 1'b1;
            inc_state <= REPEAT;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        LOCKOUT: begin
          if (!inc_held) inc_state <= IDLE;
        end
        default: inc_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam int D = 4, H = 20, R = 8, T = 100, B = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       KEY_MODE = 1'b1;
  logic       KEY_INC = 1'b1;
  logic       INCREMENT, SET_ACTIVE, BLINK;
  logic [1:0] ORDER;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  time_set_ctrl #(
    .CLOCK_FREQ(1000), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R), .TIMEOUT_CYCLES(T), .BLINK_CYCLES(B)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .INCREMENT(INCREMENT), .ORDER(ORDER), .SET_ACTIVE(SET_ACTIVE), .BLINK(BLINK)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // INCREMENT must never repeat on back-to-back cycles nor appear in RUN.
  logic prev_inc = 1'b0;
  always @(negedge CLK) begin
    if (RST === 1'b1 && INCREMENT === 1'b1)
      chk("inc_legal", int'(prev_inc) + int'(ORDER == 2'b00), 0);
    prev_inc = (INCREMENT === 1'b1);
  end

  typedef struct {
    logic       mode_low;
    logic       inc_low;
    int         low_n;
    int         high_n;
    logic [1:0] exp_order;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int p;
    vecs[0]  = '{1'b1, 1'b0, 10, 10, 2'b11, 0};
    vecs[1]  = '{1'b1, 1'b0, 10, 10, 2'b10, 0};
    vecs[2]  = '{1'b1, 1'b0, 10, 10, 2'b01, 0};
    vecs[3]  = '{1'b1, 1'b0, 10, 10, 2'b00, 0};
    vecs[4]  = '{1'b0, 1'b1, 10, 10, 2'b00, 0};
    vecs[5]  = '{1'b1, 1'b0, 10, 10, 2'b11, 0};
    vecs[6]  = '{1'b0, 1'b1, 10, 10, 2'b11, 1};
    vecs[7]  = '{1'b0, 1'b1, 10, 10, 2'b11, 1};
    vecs[8]  = '{1'b1, 1'b1, 10, 10, 2'b10, 0};
    vecs[9]  = '{1'b0, 1'b1, 28, 12, 2'b10, 2};
    vecs[10] = '{1'b1, 1'b0, 10, 10, 2'b01, 0};
    vecs[11] = '{1'b1, 1'b0, 10, 10, 2'b00, 0};

    // reset values
    repeat (3) tick();
    chk("rst order", ORDER, 0);
    chk("rst increment", INCREMENT, 0);
    chk("rst set_active", SET_ACTIVE, 0);
    chk("rst blink", BLINK, 1);
    RST = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 12; i++) begin
      p = 0;
      KEY_MODE = !vecs[i].mode_low;
      KEY_INC  = !vecs[i].inc_low;
      for (int c = 0; c < vecs[i].low_n; c++) begin tick(); p += int'(INCREMENT); end
      KEY_MODE = 1'b1;
      KEY_INC  = 1'b1;
      for (int c = 0; c < vecs[i].high_n; c++) begin tick(); p += int'(INCREMENT); end
      chk($sformatf("vec%0d order", i), ORDER, vecs[i].exp_order);
      chk($sformatf("vec%0d set_active", i), SET_ACTIVE, int'(vecs[i].exp_order != 2'b00));
      chk($sformatf("vec%0d pulses", i), p, vecs[i].exp_pulses);
    end

    // enter hours, then hold INC for 60 cycles: pulses at 7, 27, 35, 43, 51, 59
    KEY_MODE = 1'b0;
    repeat (10) tick();
    KEY_MODE = 1'b1;
    repeat (10) tick();
    chk("hold pre order", ORDER, 3);
    KEY_INC = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      chk($sformatf("hold_rep c=%0d", c), INCREMENT,
          int'(c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59));
      if (c == 60) KEY_INC = 1'b1;
    end

    // bouncing INC for 28 cycles, then a clean low: one pulse at +7
    p = 0;
    for (int i = 0; i < 14; i++) begin
      KEY_INC = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin tick(); p += int'(INCREMENT); end
    end
    chk("bounce pulses", p, 0);
    KEY_INC = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("bounce_final c=%0d", c), INCREMENT, int'(c == 7));
    end
    KEY_INC = 1'b1;
    repeat (20) tick();

    // step to minutes; check blink restart then inactivity timeout
    KEY_MODE = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      tick();
      if (c == 10) KEY_MODE = 1'b1;
      if (c == 7)   begin chk("blink order", ORDER, 2); chk("blink c7", BLINK, 1); end
      if (c == 16)  chk("blink c16", BLINK, 1);
      if (c == 17)  chk("blink c17", BLINK, 0);
      if (c == 27)  chk("blink c27", BLINK, 1);
      if (c == 106) chk("timeout c106 order", ORDER, 2);
      if (c == 107) begin
        chk("timeout c107 order", ORDER, 0);
        chk("timeout c107 blink", BLINK, 1);
        chk("timeout c107 set_active", SET_ACTIVE, 0);
      end
    end

    // both keys together in RUN: mode steps, INC locked out until re-press
    p = 0;
    KEY_MODE = 1'b0;
    KEY_INC  = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      p += int'(INCREMENT);
      if (c == 8) chk("both order", ORDER, 3);
      if (c == 10) KEY_MODE = 1'b1;
      if (c == 40) KEY_INC = 1'b1;
    end
    chk("both pulses", p, 0);
    KEY_INC = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("repress c=%0d", c), INCREMENT, int'(c == 7));
    end
    KEY_INC = 1'b1;
    repeat (12) tick();
    chk("repress order", ORDER, 3);

    // reset during REPEAT with INC still held
    p = 0;
    KEY_INC = 1'b0;
    for (int c = 1; c <= 40; c++) begin tick(); p += int'(INCREMENT); end
    chk("pre_reset pulses", p, 3);
    RST = 1'b0;
    tick();
    chk("mid_rst order", ORDER, 0);
    chk("mid_rst increment", INCREMENT, 0);
    chk("mid_rst blink", BLINK, 1);
    chk("mid_rst set_active", SET_ACTIVE, 0);
    RST = 1'b1;
    p = 0;
    for (int c = 1; c <= 60; c++) begin tick(); p += int'(INCREMENT); end
    chk("post_rst pulses", p, 0);
    chk("post_rst order", ORDER, 0);
    KEY_INC = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
